fib_rr_scheduler: RTL and testbench

//  Shares one sequential Fibonacci engine among NREQ requesters.

---
 rtl/fib_rr_scheduler_pkg.sv | 15 +
 rtl/fib_rr_scheduler_if.sv | 26 ++
 rtl/fib_rr_scheduler_engine.sv | 44 ++++
 rtl/fib_rr_scheduler.sv | 121 ++++++++++++
 tb/tb_fib_rr_scheduler.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fib_rr_scheduler_pkg.sv
// Shared definitions for the Fibonacci round-robin scheduler:
// FSM encoding and default datapath sizes.
package fib_rr_scheduler_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_NW   = 12;
    localparam int DEF_DW   = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fib_rr_scheduler_if.sv
// Requester-side bus of the scheduler: request/number in, grant/done/result out.
interface fib_rr_scheduler_if
    import fib_rr_scheduler_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int NW   = DEF_NW,
    parameter int DW   = DEF_DW
);
    logic [NREQ-1:0]    req;
    logic [NREQ*NW-1:0] req_number;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      result;
    logic               ovf;
    logic               busy;

    modport master (
        output req, req_number,
        input  grant, done, result, ovf, busy
    );

    modport slave (
        input  req, req_number,
        output grant, done, result, ovf, busy
    );
endinterface

// File: rtl/fib_rr_scheduler_engine.sv
// Sequential Fibonacci engine: a holds F(cnt), b holds F(cnt+1) with one
// spare bit so the overflow of F(cnt+1) is visible before it can wrap.
module fib_rr_scheduler_engine #(
    parameter int NW = 12,
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          start,
    input  logic          step,
    input  logic [NW-1:0] num,
    output logic          fin,
    output logic [DW-1:0] res,
    output logic          ovf
);
    logic [DW-1:0] a;
    logic [DW:0]   b;
    logic [NW-1:0] cnt;
    logic [NW-1:0] num_q;

    // load the job on start, then advance one Fibonacci step per enabled cycle
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            a     <= '0;
            b     <= '0;
            cnt   <= '0;
            num_q <= '0;
        end else if (start) begin
            a     <= '0;
            b     <= {{DW{1'b0}}, 1'b1};
            cnt   <= '0;
            num_q <= num;
        end else if (step) begin
            // step is only taken while b[DW]==0, so a copy of b fits in DW bits
            a   <= b[DW-1:0];
            b   <= {1'b0, a} + b;
            cnt <= cnt + 1'b1;
        end
    end

    assign fin = (cnt == num_q);
    assign ovf = b[DW];
    assign res = a;
endmodule

// File: rtl/fib_rr_scheduler.sv
// Round-robin front end for a single shared Fibonacci engine: picks one
// requester, runs its job to completion and returns the result with a
// one-cycle done pulse to that requester.
//
//  state  | meaning
//  S_IDLE | waiting; captures the next request in rotate-priority order
//  S_RUN  | engine iterating for the owner; grant held
//  S_DONE | done pulse to owner; pointer advances past owner
module fib_rr_scheduler
    import fib_rr_scheduler_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int NW   = DEF_NW,
    parameter int DW   = DEF_DW
) (
    input  logic              CLK,
    input  logic              reset_n,
    fib_rr_scheduler_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic [NW-1:0]   pick_num;
    int              cand;
    logic [NREQ-1:0] owner_oh;
    logic            eng_start;
    logic            eng_step;
    logic            eng_fin;
    logic            eng_ovf;
    logic [DW-1:0]   eng_res;

    // rotate-priority search from rr_ptr; scanning far-to-near lets the nearest win
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = (int'(rr_ptr) + k) % NREQ;
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

    assign pick_num  = bus.req_number[int'(pick_idx) * NW +: NW];
    assign owner_oh  = NREQ'(1) << owner;
    assign eng_start = (state == S_IDLE) && pick_valid;
    assign eng_step  = (state == S_RUN) && !eng_fin && !eng_ovf;

    fib_rr_scheduler_engine #(
        .NW (NW),
        .DW (DW)
    ) u_engine (
        .CLK     (CLK),
        .reset_n (reset_n),
        .start   (eng_start),
        .step    (eng_step),
        .num     (pick_num),
        .fin     (eng_fin),
        .res     (eng_res),
        .ovf     (eng_ovf)
    );

    // job sequencing FSM with registered grant/done/result/ovf/busy
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            bus.grant  <= '0;
            bus.done   <= '0;
            bus.result <= '0;
            bus.ovf    <= 1'b0;
            bus.busy   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.done <= '0;
                    if (pick_valid) begin
                        owner     <= pick_idx;
                        bus.grant <= NREQ'(1) << pick_idx;
                        bus.busy  <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (eng_fin) begin
                        bus.result <= eng_res;
                        bus.ovf    <= 1'b0;
                        bus.done   <= owner_oh;
                        state      <= S_DONE;
                    end else if (eng_ovf) begin
                        // F(cnt+1) already overflowed, so F(num) will too
                        bus.result <= '1;
                        bus.ovf    <= 1'b1;
                        bus.done   <= owner_oh;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.done  <= '0;
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                    rr_ptr    <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    bus.done  <= '0;
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fib_rr_scheduler.sv
// Bench for fib_rr_scheduler: directed cases plus randomized rounds checked
// against a job-level model (Fibonacci table, overflow cut-off, rotating pick).
module tb_fib_rr_scheduler;
    localparam int NREQ = 4;
    localparam int NW   = 12;
    localparam int DW   = 16;

    logic   CLK     = 1'b0;
    logic   reset_n = 1'b0;
    int     n_checks = 0;
    int     n_fail   = 0;
    int     m_ptr    = 0;
    longint fibtab[0:40];
    int     kov;

    fib_rr_scheduler_if #(.NREQ(NREQ), .NW(NW), .DW(DW)) bus();

    fib_rr_scheduler #(
        .NREQ (NREQ),
        .NW   (NW),
        .DW   (DW)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // a job overflows when it would still be running once F(cnt+1) >= 2^DW
    function automatic bit model_ovf(input int n);
        return n > kov;
    endfunction

    function automatic longint model_res(input int n);
        return model_ovf(n) ? ((longint'(1) << DW) - 1) : fibtab[n];
    endfunction

    // cycles from request to done pulse
    function automatic int model_lat(input int n);
        return (model_ovf(n) ? kov : n) + 2;
    endfunction

    function automatic int model_pick(input int ptr, input logic [NREQ-1:0] pend);
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [NREQ*NW-1:0] pack1(input int idx, input int n);
        logic [NREQ*NW-1:0] v;
        v = '0;
        v[idx*NW +: NW] = NW'(n);
        return v;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        reset_n = 1'b0;
        bus.req = '0;
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        m_ptr = 0;
    endtask

    // raise all requests in mask together, serve them, drop each on its done
    task automatic run_round(input logic [NREQ-1:0] mask, input logic [NREQ*NW-1:0] nums);
        logic [NREQ-1:0] pend;
        logic [DW-1:0]   last_res;
        int cyc, g_cyc, owner, n;
        bit first, in_job;
        pend = mask; cyc = 0; g_cyc = 0; owner = 0; first = 1'b1; in_job = 1'b0;
        @(negedge CLK);
        bus.req_number = nums;
        bus.req = mask;
        while (pend != '0 && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            if (!in_job && bus.grant != '0) begin
                in_job = 1'b1;
                g_cyc = cyc;
                owner = model_pick(m_ptr, pend);
                check_val("grant", bus.grant, 64'(1) << owner);
                check_val("busy", bus.busy, 1);
                if (first) check_val("grant_latency", cyc, 1);
            end
            if (bus.done != '0) begin
                if (!in_job) begin
                    check_val("done_without_grant", bus.done, 0);
                    owner = model_pick(m_ptr, pend);
                end
                n = int'(nums[owner*NW +: NW]);
                check_val("done_owner", bus.done, 64'(1) << owner);
                check_val("grant_at_done", bus.grant, 64'(1) << owner);
                check_val("result", bus.result, model_res(n));
                check_val("ovf", bus.ovf, model_ovf(n));
                check_val("grant_to_done", cyc - g_cyc, model_lat(n) - 1);
                if (first) check_val("req_to_done", cyc, model_lat(n));
                last_res = bus.result;
                bus.req[owner] = 1'b0;
                pend[owner] = 1'b0;
                m_ptr = (owner + 1) % NREQ;
                in_job = 1'b0;
                first = 1'b0;
                @(negedge CLK);
                cyc++;
                check_val("gap_busy", bus.busy, 0);
                check_val("gap_grant", bus.grant, 0);
                check_val("gap_done", bus.done, 0);
                check_val("result_hold", bus.result, last_res);
            end
        end
        if (pend != '0) begin
            check_val("round_timeout", pend, 0);
            bus.req = '0;
        end
    endtask

    initial begin
        logic [NREQ*NW-1:0] nums;
        logic [NREQ-1:0]    mask;
        int done_cnt;

        fibtab[0] = 0;
        fibtab[1] = 1;
        for (int k = 2; k <= 40; k++) fibtab[k] = fibtab[k-1] + fibtab[k-2];
        kov = 0;
        for (int k = 39; k >= 0; k--) begin
            if (fibtab[k+1] >= (longint'(1) << DW)) kov = k;
        end

        bus.req = '0;
        bus.req_number = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("rst_grant", bus.grant, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_result", bus.result, 0);
        check_val("rst_ovf", bus.ovf, 0);
        check_val("rst_busy", bus.busy, 0);
        reset_n = 1'b1;

        // single jobs, small n and the overflow boundary
        run_round(4'b0001, pack1(0, 10));
        run_round(4'b0001, pack1(0, 0));
        run_round(4'b0001, pack1(0, 1));
        run_round(4'b0001, pack1(0, 2));
        run_round(4'b0001, pack1(0, 24));
        run_round(4'b0001, pack1(0, 25));
        run_round(4'b0001, pack1(0, 4095));

        // all four together from a fresh pointer, then 0 and 3
        do_reset();
        nums = {12'd6, 12'd5, 12'd4, 12'd3};
        run_round(4'b1111, nums);
        run_round(4'b1001, nums);

        // reset in the middle of a job
        @(negedge CLK);
        bus.req_number = pack1(2, 20);
        bus.req = 4'b0100;
        repeat (8) @(negedge CLK);
        check_val("abort_busy_before", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        check_val("abort_grant", bus.grant, 0);
        check_val("abort_done", bus.done, 0);
        check_val("abort_result", bus.result, 0);
        check_val("abort_busy", bus.busy, 0);
        bus.req = '0;
        repeat (3) @(negedge CLK);
        reset_n = 1'b1;
        m_ptr = 0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (bus.done != '0) done_cnt++;
        end
        check_val("abort_no_done", done_cnt, 0);
        run_round(4'b0100, pack1(2, 20));

        // owner withdraws and changes its number mid-run
        @(negedge CLK);
        bus.req_number = pack1(1, 15);
        bus.req = 4'b0010;
        done_cnt = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge CLK);
            if (c == 5) begin
                bus.req = '0;
                bus.req_number[NW +: NW] = 12'd3;
            end
            if (bus.done != '0) begin
                done_cnt++;
                check_val("drop_done_owner", bus.done, 4'b0010);
                check_val("drop_result", bus.result, fibtab[15]);
                check_val("drop_latency", c, model_lat(15));
            end
        end
        check_val("drop_done_count", done_cnt, 1);
        m_ptr = 2;

        // randomized rounds
        for (int r = 0; r < 30; r++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 4) == 0)
                    nums[i*NW +: NW] = NW'($urandom_range(0, (1 << NW) - 1));
                else
                    nums[i*NW +: NW] = NW'($urandom_range(0, 30));
            end
            run_round(mask, nums);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
